fm_bus_arbiter: RTL and testbench
=================================

FM_BUS_ARBITER -- requirements
Module: fm_bus_arbiter

Interface
REQ-001 SHALL have parameter BUSY_DATA, default 32, CKE ticks of write hold-off after a data-port write.
REQ-002 SHALL have parameter BUSY_ADDR, default 2, CKE ticks of write hold-off after an address-port write.
REQ-003 SHALL have parameter TMO_CYC, default 255, MCLK cycles to wait for FM_DTACK_N before aborting.
REQ-004 SHALL have parameter LOCK_TMO, default 64, CKE ticks an address lock survives without an owner request.
REQ-005 One clock, MCLK; reset is synchronous and active-high, RST.
REQ-006 Ports:
- MCLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- CKE  in  1  FM clock enable, shared with the FM core
- A_REQ  in  1  port A (68K) request, held until A_ACK
- A_ADDR  in  2  port A FM address
- A_RNW  in  1  port A 1=read
- A_WDATA  in  8  port A write data
- A_ACK  out  1  port A one-cycle completion pulse
- A_RDATA  out  8  port A read data, valid with A_ACK
- B_REQ, B_ADDR, B_RNW, B_WDATA, B_ACK, B_RDATA  same as port A, for port B (Z80)
- FM_SEL  out  1  FM core select
- FM_ADDR  out  2  FM core address
- FM_RNW  out  1  FM core read/not-write
- FM_WDATA  out  8  FM core write data
- FM_RDATA  in  8  FM core status
- FM_DTACK_N  in  1  FM core acknowledge, active-low
- BUSY  out  1  write hold-off active
- ERR  out  1  sticky timeout flag

Function
REQ-007 SHALL implement FSM IDLE -> HOLD -> ISSUE -> DONE -> IDLE.
- IDLE: grant one request.
- HOLD: wait out the busy counter (writes only).
- ISSUE: FM_SEL=1.
- DONE: FM_SEL=0, ACK pulse.
REQ-008 Arbitration in IDLE SHALL follow these rules:
- If a lock owner exists, only the owner is eligible.
- Otherwise, with both requesting, the port not granted last wins.
- After reset, priority goes to A.
REQ-009 On grant, SHALL latch ADDR, RNW and WDATA. FM_ADDR/FM_RNW/FM_WDATA SHALL come from the latch and be stable for the whole ISSUE state.
REQ-010 A granted write with busy counter nonzero SHALL enter HOLD and proceed to ISSUE in the cycle after the counter reaches 0. Reads and zero-count writes SHALL go straight to ISSUE.
REQ-011 In ISSUE, the sampled FM_DTACK_N==0 SHALL move to DONE. FM_RDATA SHALL be captured, with bit7 replaced by BUSY.
REQ-012 In DONE, SHALL drive FM_SEL=0 and pulse the granted port's ACK for exactly 1 MCLK with RDATA valid. FM_SEL SHALL therefore be low at least 1 cycle between accesses.
REQ-013 In the DONE cycle of a write, SHALL load the busy counter:
- BUSY_DATA if ADDR[0]=1;
- BUSY_ADDR if ADDR[0]=0.
REQ-014 The busy counter SHALL decrement by 1 on each CKE=1 cycle while nonzero, saturating at 0. BUSY SHALL equal (counter != 0).
REQ-015 A load and a CKE decrement in the same cycle SHALL resolve to the load value.
REQ-016 Write to ADDR[0]=0 by port X SHALL set lock owner X.
REQ-017 The lock SHALL clear on any of:
- X's write to ADDR[0]=1;
- X writing to the other bank address (ADDR[1] differs), in which case ownership is retaken;
- LOCK_TMO CKE ticks with no X request.
REQ-018 The lock timer SHALL reload on every owner grant.
REQ-019 Timeout: if ISSUE lasts TMO_CYC cycles without DTACK, SHALL go to DONE with RDATA=8'hFF and set ERR, and SHALL NOT load the busy counter. ERR SHALL clear only on RST.
REQ-020 A requester dropping REQ before ACK is illegal. The arbiter SHALL still complete the latched access and issue the ACK.
REQ-021 Simultaneous A_REQ and B_REQ rising in the same cycle with no lock SHALL be granted by REQ-008 ordering. The loser SHALL be served next, with no starvation beyond one access.

Reset
REQ-022 On RST=1 at a MCLK edge, SHALL clear state regardless of any access in flight, with no ACK issued for the aborted access:
- state IDLE, FM_SEL=0, FM_ADDR=0, FM_RNW=1, FM_WDATA=0;
- A_ACK=B_ACK=0, A_RDATA=B_RDATA=0;
- busy counter 0, BUSY=0, ERR=0;
- lock cleared, priority to A, timers 0.

Structure
REQ-023 Package fm_arb_pkg SHALL hold the FSM state encoding, the port-id constants (PORT_A=0, PORT_B=1) and the parameter defaults.
REQ-024 Sub-module fm_busy_timer (counter, load/decrement on CKE, BUSY out) SHALL be instantiated once. All other logic stays flat.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset, then A writes addr 0x2A: FM_SEL high within 2 cycles, A_ACK 1 cycle after DTACK, BUSY=1 for 2 CKE ticks.
- A writes ADDR=0 (0x28), then B and A both request: only A served until A writes ADDR=1 (0xF0); B served next.
- Back-to-back A data writes, CKE every 4 MCLK: second FM_SEL rises no earlier than 32 CKE ticks (>=128 MCLK) after first DONE.
- B read during BUSY: read issued without hold-off; B_RDATA[7]=1, B_RDATA[1:0]=FM timer flags.
- FM_DTACK_N stuck high: ACK after 255 ISSUE cycles, RDATA=0xFF, ERR=1, BUSY unchanged.
- RST asserted mid-ISSUE: next cycle FM_SEL=0, no ACK, BUSY=0, lock cleared.

Source files
------------

// File: rtl/fm_arb_pkg.sv
// Shared constants for the FM bus arbiter: FSM encoding, port ids,
// parameter defaults and a counter-width helper.
package fm_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_HOLD  = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   localparam int BUSY_DATA_DEF = 32;
   localparam int BUSY_ADDR_DEF = 2;
   localparam int TMO_CYC_DEF   = 255;
   localparam int LOCK_TMO_DEF  = 64;

   // Bits needed to hold values 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/fm_busy_timer.sv
// Write hold-off counter: loads on request, counts down on each clock-enable
// tick, saturates at zero. A load wins over a same-cycle decrement.
module fm_busy_timer #(
   parameter int WIDTH = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cke_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic             busy_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cke_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/fm_bus_arbiter.sv
// Two-port (68K / Z80) arbiter in front of the FM core: grant, write hold-off,
// single FM access with DTACK timeout, and a per-port address lock.
module fm_bus_arbiter
   import fm_arb_pkg::*;
#(
   parameter int BUSY_DATA = BUSY_DATA_DEF,
   parameter int BUSY_ADDR = BUSY_ADDR_DEF,
   parameter int TMO_CYC   = TMO_CYC_DEF,
   parameter int LOCK_TMO  = LOCK_TMO_DEF
) (
   input  logic       MCLK,
   input  logic       RST,
   input  logic       CKE,
   input  logic       A_REQ,
   input  logic [1:0] A_ADDR,
   input  logic       A_RNW,
   input  logic [7:0] A_WDATA,
   output logic       A_ACK,
   output logic [7:0] A_RDATA,
   input  logic       B_REQ,
   input  logic [1:0] B_ADDR,
   input  logic       B_RNW,
   input  logic [7:0] B_WDATA,
   output logic       B_ACK,
   output logic [7:0] B_RDATA,
   output logic       FM_SEL,
   output logic [1:0] FM_ADDR,
   output logic       FM_RNW,
   output logic [7:0] FM_WDATA,
   input  logic [7:0] FM_RDATA,
   input  logic       FM_DTACK_N,
   output logic       BUSY,
   output logic       ERR
);

   localparam int BW = cnt_width((BUSY_DATA > BUSY_ADDR) ? BUSY_DATA : BUSY_ADDR);
   localparam int TW = cnt_width(TMO_CYC);
   localparam int LW = cnt_width(LOCK_TMO);

   logic [1:0]    state_q, state_d;
   logic          gnt_q, gnt_d;
   logic          last_q, last_d;
   logic [1:0]    addr_q, addr_d;
   logic          rnw_q, rnw_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          tout_q, tout_d;
   logic          err_q, err_d;
   logic [7:0]    rdata_a_q, rdata_a_d;
   logic [7:0]    rdata_b_q, rdata_b_d;
   logic          lock_vld_q, lock_vld_d;
   logic          lock_own_q, lock_own_d;
   logic [LW-1:0] lock_tmr_q, lock_tmr_d;

   logic          busy;
   logic          busy_load;
   logic [BW-1:0] busy_val;
   logic          elig_a, elig_b, any_elig, pick;
   logic [1:0]    pick_addr;
   logic          pick_rnw;
   logic [7:0]    pick_wdata;
   logic [7:0]    cap;
   logic          owner_req;

   // A timed-out write never reached the core, so it does not start a hold-off.
   assign busy_load = (state_q == ST_DONE) && !rnw_q && !tout_q;
   assign busy_val  = addr_q[0] ? BW'(BUSY_DATA) : BW'(BUSY_ADDR);

   fm_busy_timer #(
      .WIDTH (BW)
   ) u_busy_timer (
      .clk_i      (MCLK),
      .rst_i      (RST),
      .cke_i      (CKE),
      .load_i     (busy_load),
      .load_val_i (busy_val),
      .busy_o     (busy)
   );

   // While a lock is held only its owner may be granted; otherwise alternate.
   always_comb begin
      elig_a   = A_REQ && (!lock_vld_q || (lock_own_q == PORT_A));
      elig_b   = B_REQ && (!lock_vld_q || (lock_own_q == PORT_B));
      any_elig = elig_a || elig_b;
      if (elig_a && elig_b) begin
         pick = (last_q == PORT_A) ? PORT_B : PORT_A;
      end else begin
         pick = elig_b ? PORT_B : PORT_A;
      end
      pick_addr  = (pick == PORT_B) ? B_ADDR  : A_ADDR;
      pick_rnw   = (pick == PORT_B) ? B_RNW   : A_RNW;
      pick_wdata = (pick == PORT_B) ? B_WDATA : A_WDATA;
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      addr_d    = addr_q;
      rnw_d     = rnw_q;
      wdata_d   = wdata_q;
      tmo_d     = tmo_q;
      tout_d    = tout_q;
      err_d     = err_q;
      rdata_a_d = rdata_a_q;
      rdata_b_d = rdata_b_q;
      cap       = FM_RDATA;
      cap[7]    = busy;

      case (state_q)
         ST_IDLE: begin
            if (any_elig) begin
               gnt_d   = pick;
               last_d  = pick;
               addr_d  = pick_addr;
               rnw_d   = pick_rnw;
               wdata_d = pick_wdata;
               tmo_d   = '0;
               tout_d  = 1'b0;
               state_d = (!pick_rnw && busy) ? ST_HOLD : ST_ISSUE;
            end
         end
         ST_HOLD: begin
            if (!busy) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!FM_DTACK_N) begin
               state_d = ST_DONE;
            end else if (tmo_q == TW'(TMO_CYC - 1)) begin
               state_d = ST_DONE;
               cap     = 8'hFF;
               tout_d  = 1'b1;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
            if (state_d == ST_DONE) begin
               if (gnt_q == PORT_A) rdata_a_d = cap;
               else                 rdata_b_d = cap;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // An address-port write (re)takes the lock, which covers the bank-switch
   // case: the old lock ends and the writer becomes owner again.
   always_comb begin
      lock_vld_d = lock_vld_q;
      lock_own_d = lock_own_q;
      lock_tmr_d = lock_tmr_q;
      owner_req  = (lock_own_q == PORT_B) ? B_REQ : A_REQ;

      if ((state_q == ST_DONE) && !rnw_q) begin
         if (!addr_q[0]) begin
            lock_vld_d = 1'b1;
            lock_own_d = gnt_q;
            lock_tmr_d = LW'(LOCK_TMO);
         end else if (lock_vld_q && (lock_own_q == gnt_q)) begin
            lock_vld_d = 1'b0;
            lock_tmr_d = '0;
         end
      end else if (lock_vld_q) begin
         if (owner_req) begin
            lock_tmr_d = LW'(LOCK_TMO);
         end else if (CKE) begin
            if (lock_tmr_q <= LW'(1)) begin
               lock_vld_d = 1'b0;
               lock_tmr_d = '0;
            end else begin
               lock_tmr_d = lock_tmr_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge MCLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         gnt_q      <= PORT_A;
         last_q     <= PORT_B;
         addr_q     <= 2'd0;
         rnw_q      <= 1'b1;
         wdata_q    <= 8'd0;
         tmo_q      <= '0;
         tout_q     <= 1'b0;
         err_q      <= 1'b0;
         rdata_a_q  <= 8'd0;
         rdata_b_q  <= 8'd0;
         lock_vld_q <= 1'b0;
         lock_own_q <= PORT_A;
         lock_tmr_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         addr_q     <= addr_d;
         rnw_q      <= rnw_d;
         wdata_q    <= wdata_d;
         tmo_q      <= tmo_d;
         tout_q     <= tout_d;
         err_q      <= err_d;
         rdata_a_q  <= rdata_a_d;
         rdata_b_q  <= rdata_b_d;
         lock_vld_q <= lock_vld_d;
         lock_own_q <= lock_own_d;
         lock_tmr_q <= lock_tmr_d;
      end
   end

   assign FM_SEL   = (state_q == ST_ISSUE);
   assign FM_ADDR  = addr_q;
   assign FM_RNW   = rnw_q;
   assign FM_WDATA = wdata_q;
   assign A_ACK    = (state_q == ST_DONE) && (gnt_q == PORT_A);
   assign B_ACK    = (state_q == ST_DONE) && (gnt_q == PORT_B);
   assign A_RDATA  = rdata_a_q;
   assign B_RDATA  = rdata_b_q;
   assign BUSY     = busy;
   assign ERR      = err_q;

endmodule

// File: tb/tb_fm_bus_arbiter.sv
// Directed bench for fm_bus_arbiter: stimulus and sampling happen on the
// falling edge; a small FM model answers DTACK while enabled.
module tb_fm_bus_arbiter;
   import fm_arb_pkg::*;

   logic       MCLK = 1'b0;
   logic       RST  = 1'b1;
   logic       CKE  = 1'b0;
   logic       A_REQ = 1'b0, B_REQ = 1'b0;
   logic [1:0] A_ADDR = 2'd0, B_ADDR = 2'd0;
   logic       A_RNW = 1'b1, B_RNW = 1'b1;
   logic [7:0] A_WDATA = 8'd0, B_WDATA = 8'd0;
   logic       A_ACK, B_ACK;
   logic [7:0] A_RDATA, B_RDATA;
   logic       FM_SEL, FM_RNW;
   logic [1:0] FM_ADDR;
   logic [7:0] FM_WDATA;
   logic [7:0] FM_RDATA = 8'h03;
   logic       FM_DTACK_N;
   logic       BUSY, ERR;

   int n_chk = 0, n_pass = 0, n_fail = 0;
   int busy_ticks = 0;
   int cke_div = 1, cke_phase = 0;
   bit cke_en = 1'b1, dtack_en = 1'b1;

   fm_bus_arbiter dut (
      .MCLK(MCLK), .RST(RST), .CKE(CKE),
      .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_RNW(A_RNW), .A_WDATA(A_WDATA),
      .A_ACK(A_ACK), .A_RDATA(A_RDATA),
      .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_RNW(B_RNW), .B_WDATA(B_WDATA),
      .B_ACK(B_ACK), .B_RDATA(B_RDATA),
      .FM_SEL(FM_SEL), .FM_ADDR(FM_ADDR), .FM_RNW(FM_RNW), .FM_WDATA(FM_WDATA),
      .FM_RDATA(FM_RDATA), .FM_DTACK_N(FM_DTACK_N), .BUSY(BUSY), .ERR(ERR)
   );

   always #5 MCLK = ~MCLK;

   // FM core model: acknowledges immediately while selected, unless disabled.
   assign FM_DTACK_N = !(FM_SEL && dtack_en);

   always @(negedge MCLK) begin
      cke_phase = (cke_phase + 1) % cke_div;
      CKE = cke_en && (cke_phase == 0);
   end

   // Counts busy-counter decrement events (counter nonzero while CKE high).
   always @(posedge MCLK) if (BUSY && CKE) busy_ticks++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge MCLK);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic port, input logic req, input logic rnw,
                          input logic [1:0] addr, input logic [7:0] wdata);
      if (port == PORT_A) begin
         A_REQ = req; A_RNW = rnw; A_ADDR = addr; A_WDATA = wdata;
      end else begin
         B_REQ = req; B_RNW = rnw; B_ADDR = addr; B_WDATA = wdata;
      end
   endtask

   // which: 0 = A acked, 1 = B acked, -1 = nothing within budget.
   task automatic wait_ack(input int budget, output int which, output int cyc);
      which = -1;
      cyc   = 0;
      while (which < 0 && cyc < budget) begin
         tick();
         cyc++;
         if (A_ACK) which = 0;
         else if (B_ACK) which = 1;
      end
   endtask

   task automatic wait_sel(input int budget, output int cyc);
      cyc = 0;
      while (!FM_SEL && cyc <= budget) begin
         tick();
         cyc++;
      end
   endtask

   task automatic wait_busy_clear(input int budget);
      int n = 0;
      while (BUSY && n < budget) begin
         tick();
         n++;
      end
      check("busy_clears", BUSY, 0);
   endtask

   initial begin
      int which, cyc, t0, hi;
      logic seen_sel, seen_ack;

      // ---------------- reset ----------------
      repeat (3) tick();
      check("rst_fm_sel", FM_SEL, 0);
      check("rst_fm_addr", FM_ADDR, 0);
      check("rst_fm_rnw", FM_RNW, 1);
      check("rst_fm_wdata", FM_WDATA, 0);
      check("rst_acks", {A_ACK, B_ACK}, 0);
      check("rst_rdata", {A_RDATA, B_RDATA}, 0);
      check("rst_busy_err", {BUSY, ERR}, 0);
      RST = 1'b0;
      tick();

      // ---------------- S1: A address write 0x2A ----------------
      set_req(PORT_A, 1, 0, 2'd0, 8'h2A);
      wait_sel(4, cyc);
      check("s1_sel_within_2", (cyc >= 1 && cyc <= 2), 1);
      check("s1_fm_bus", {FM_ADDR, FM_RNW, FM_WDATA}, {2'd0, 1'b0, 8'h2A});
      tick();
      check("s1_ack_after_dtack", A_ACK, 1);
      check("s1_rdata", A_RDATA, 8'h03);
      t0 = busy_ticks;
      set_req(PORT_A, 0, 1, 2'd0, 8'h00);
      tick();
      check("s1_ack_one_cycle", {A_ACK, FM_SEL}, 0);
      check("s1_busy_set", BUSY, 1);
      wait_busy_clear(20);
      check("s1_busy_ticks", busy_ticks - t0, 2);

      // ---------------- S2: lock by A, B waits ----------------
      set_req(PORT_A, 1, 0, 2'd0, 8'h28);
      wait_ack(10, which, cyc);
      check("s2_lock_write", which, 0);
      set_req(PORT_A, 0, 1, 2'd0, 8'h00);
      tick();
      set_req(PORT_B, 1, 1, 2'd1, 8'h00);
      set_req(PORT_A, 1, 0, 2'd2, 8'h30);
      wait_ack(20, which, cyc);
      check("s2_owner_first", which, 0);
      set_req(PORT_A, 0, 1, 2'd0, 8'h00);
      seen_sel = 1'b0;
      seen_ack = 1'b0;
      repeat (4) begin
         tick();
         seen_sel |= FM_SEL;
         seen_ack |= B_ACK;
      end
      check("s2_b_blocked", {seen_sel, seen_ack}, 0);
      FM_RDATA = 8'h02;
      set_req(PORT_A, 1, 0, 2'd1, 8'hF0);
      wait_ack(20, which, cyc);
      check("s2_unlock_write", which, 0);
      set_req(PORT_A, 0, 1, 2'd0, 8'h00);
      wait_ack(10, which, cyc);
      check("s2_b_next", which, 1);
      check("s2_b_rdata_busy_bit", B_RDATA, 8'h82);
      set_req(PORT_B, 0, 1, 2'd0, 8'h00);

      // ---------------- S3: back-to-back data writes, CKE every 4 ----------------
      wait_busy_clear(60);
      cke_div = 4;
      set_req(PORT_A, 1, 0, 2'd1, 8'h11);
      wait_ack(20, which, cyc);
      check("s3_first_write", which, 0);
      t0 = busy_ticks;
      set_req(PORT_A, 1, 0, 2'd1, 8'h22);
      cyc = 0;
      while (!FM_SEL && cyc < 300) begin
         tick();
         cyc++;
      end
      // 32 ticks 4 apart: DONE edge, >=1 edge to first tick, 31 gaps of 4, one edge out of HOLD.
      check("s3_second_sel_late", (cyc >= 127), 1);
      check("s3_busy_ticks", busy_ticks - t0, 32);
      check("s3_second_wdata", FM_WDATA, 8'h22);
      wait_ack(10, which, cyc);
      check("s3_second_ack", which, 0);

      // ---------------- S4: B read during BUSY ----------------
      FM_RDATA = 8'h41;
      set_req(PORT_A, 0, 1, 2'd0, 8'h00);
      set_req(PORT_B, 1, 1, 2'd1, 8'h00);
      wait_sel(4, cyc);
      check("s4_no_holdoff", (cyc >= 1 && cyc <= 2), 1);
      check("s4_busy_during_read", BUSY, 1);
      wait_ack(10, which, cyc);
      check("s4_b_ack", which, 1);
      check("s4_b_rdata", B_RDATA, 8'hC1);
      set_req(PORT_B, 0, 1, 2'd0, 8'h00);

      // ---------------- S5: DTACK stuck high ----------------
      cke_div = 1;
      wait_busy_clear(80);
      dtack_en = 1'b0;
      set_req(PORT_A, 1, 0, 2'd1, 8'h55);
      wait_sel(4, cyc);
      hi = 0;
      while (FM_SEL && hi < 400) begin
         hi++;
         tick();
      end
      check("s5_issue_cycles", hi, 255);
      check("s5_ack", A_ACK, 1);
      check("s5_rdata_ff", A_RDATA, 8'hFF);
      check("s5_err", ERR, 1);
      set_req(PORT_A, 0, 1, 2'd0, 8'h00);
      dtack_en = 1'b1;
      tick();
      check("s5_no_busy_load", BUSY, 0);

      // ---------------- S6: lock expires after 64 idle ticks ----------------
      set_req(PORT_A, 1, 0, 2'd0, 8'h2B);
      wait_ack(10, which, cyc);
      check("s6_lock_write", which, 0);
      set_req(PORT_A, 0, 1, 2'd0, 8'h00);
      set_req(PORT_B, 1, 1, 2'd3, 8'h00);
      wait_ack(50, which, cyc);
      check("s6_lock_holds", which, -1);
      wait_ack(40, which, cyc);
      check("s6_b_after_expiry", which, 1);
      check("s6_expiry_time", 50 + cyc, 67);
      check("s6_err_sticky", ERR, 1);
      set_req(PORT_B, 0, 1, 2'd0, 8'h00);

      // ---------------- S7: reset mid-ISSUE ----------------
      cke_en = 1'b0;
      tick();
      set_req(PORT_A, 1, 0, 2'd0, 8'h2C);
      wait_ack(10, which, cyc);
      check("s7_lock_write", which, 0);
      set_req(PORT_A, 0, 1, 2'd0, 8'h00);
      tick();
      dtack_en = 1'b0;
      set_req(PORT_A, 1, 1, 2'd1, 8'h00);
      wait_sel(4, cyc);
      repeat (3) tick();
      check("s7_in_issue", {FM_SEL, BUSY}, 2'b11);
      RST = 1'b1;
      tick();
      check("s7_rst_sel", FM_SEL, 0);
      check("s7_rst_acks", {A_ACK, B_ACK}, 0);
      check("s7_rst_busy_err", {BUSY, ERR}, 0);
      check("s7_rst_bus", {FM_ADDR, FM_RNW, FM_WDATA, A_RDATA}, {2'd0, 1'b1, 8'h00, 8'h00});
      RST = 1'b0;
      set_req(PORT_A, 0, 1, 2'd0, 8'h00);
      dtack_en = 1'b1;
      cke_en = 1'b1;
      seen_ack = 1'b0;
      repeat (3) begin
         tick();
         seen_ack |= (A_ACK | B_ACK);
      end
      check("s7_no_aborted_ack", seen_ack, 0);

      // After reset: A has priority, lock gone so B follows directly.
      set_req(PORT_A, 1, 1, 2'd1, 8'h00);
      set_req(PORT_B, 1, 1, 2'd1, 8'h00);
      wait_ack(6, which, cyc);
      check("s7_prio_a", which, 0);
      set_req(PORT_A, 0, 1, 2'd0, 8'h00);
      wait_ack(6, which, cyc);
      check("s7_lock_cleared_b", which, 1);
      set_req(PORT_B, 0, 1, 2'd0, 8'h00);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
